// File: rtl/i2c_cfg_sequencer.sv
// I2C configuration sequencer: walks a synchronous-read command ROM and turns
// each WRITE entry into a register-write request for the I2C byte master.
// It also handles DELAY, END and NOP entries, retries NACKed writes, and
// reports done/error status to the bring-up controller.
module i2c_cfg_sequencer #(
   parameter int LINES       = 16,
   parameter int DW          = 32,
   parameter int MAX_RETRY   = 3,
   parameter int DELAY_SHIFT = 10,
   localparam int AW         = (LINES > 1) ? $clog2(LINES) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic [AW-1:0] rom_addr,
   input  logic [DW-1:0] rom_data,
   output logic          cmd_valid,
   input  logic          cmd_ready,
   output logic [6:0]    cmd_dev,
   output logic [7:0]    cmd_reg,
   output logic [7:0]    cmd_data,
   input  logic          rsp_valid,
   input  logic          rsp_nack,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic [AW-1:0] fail_addr
);

   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int CW = 16 + DELAY_SHIFT;

   localparam logic [7:0] OP_WRITE = 8'h00;
   localparam logic [7:0] OP_DELAY = 8'h01;
   localparam logic [7:0] OP_END   = 8'hFF;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_DECODE,
      S_ISSUE,
      S_WAIT_RSP,
      S_DELAY,
      S_NEXT,
      S_FINISH,
      S_FAIL
   } state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [RW-1:0]   retry_q, retry_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            vld_q, vld_d;
   logic [6:0]      dev_q, dev_d;
   logic [7:0]      reg_q, reg_d;
   logic [7:0]      dat_q, dat_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic [AW-1:0]   fail_q, fail_d;

   // Latched ROM word fields (bit 16 carries no meaning in any opcode)
   logic [7:0]      op_q;
   logic [6:0]      wdev_q;
   logic [15:0]     lo_q;
   logic            unused_rom_bit;

   assign unused_rom_bit = rom_data[16];

   // Capture the ROM word during LATCH, once the read latency has elapsed
   always_ff @(posedge clk) begin
      if (state_q == S_LATCH) begin
         op_q   <= rom_data[31:24];
         wdev_q <= rom_data[23:17];
         lo_q   <= rom_data[15:0];
      end
   end

   // Sequencer state, command and status registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         retry_q <= '0;
         cnt_q   <= '0;
         vld_q   <= 1'b0;
         dev_q   <= '0;
         reg_q   <= '0;
         dat_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         fail_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         retry_q <= retry_d;
         cnt_q   <= cnt_d;
         vld_q   <= vld_d;
         dev_q   <= dev_d;
         reg_q   <= reg_d;
         dat_q   <= dat_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         fail_q  <= fail_d;
      end
   end

   // Next-state logic: fetch/decode walk, handshake, retry and delay handling
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      retry_d = retry_q;
      cnt_d   = cnt_q;
      dev_d   = dev_q;
      reg_d   = reg_q;
      dat_d   = dat_q;
      busy_d  = busy_q;
      done_d  = done_q;
      err_d   = err_q;
      fail_d  = fail_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               done_d  = 1'b0;
               err_d   = 1'b0;
               retry_d = '0;
               addr_d  = '0;
               busy_d  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_FETCH:  state_d = S_LATCH;
         S_LATCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (op_q)
               OP_WRITE: begin
                  dev_d   = wdev_q;
                  reg_d   = lo_q[15:8];
                  dat_d   = lo_q[7:0];
                  state_d = S_ISSUE;
               end
               OP_DELAY: begin
                  if (lo_q == 16'd0) begin
                     state_d = S_NEXT;
                  end else begin
                     cnt_d   = CW'(lo_q) << DELAY_SHIFT;
                     state_d = S_DELAY;
                  end
               end
               OP_END:  state_d = S_FINISH;
               default: state_d = S_NEXT;
            endcase
         end
         S_ISSUE: begin
            // Response pulses are not looked at here, so one coinciding with
            // the handshake is dropped.
            if (cmd_ready) state_d = S_WAIT_RSP;
         end
         S_WAIT_RSP: begin
            if (rsp_valid) begin
               if (!rsp_nack) begin
                  retry_d = '0;
                  state_d = S_NEXT;
               end else if (retry_q < RW'(MAX_RETRY)) begin
                  retry_d = retry_q + RW'(1);
                  state_d = S_ISSUE;
               end else begin
                  state_d = S_FAIL;
               end
            end
         end
         S_DELAY: begin
            if (cnt_q == CW'(1)) state_d = S_NEXT;
            else                 cnt_d   = cnt_q - CW'(1);
         end
         S_NEXT: begin
            if (addr_q == AW'(LINES - 1)) begin
               state_d = S_FINISH;
            end else begin
               addr_d  = addr_q + AW'(1);
               state_d = S_FETCH;
            end
         end
         S_FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         S_FAIL: begin
            err_d   = 1'b1;
            fail_d  = addr_q;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Request is high exactly while in ISSUE, so it only falls after a handshake
      vld_d = (state_d == S_ISSUE);
   end

   assign rom_addr  = addr_q;
   assign cmd_valid = vld_q;
   assign cmd_dev   = dev_q;
   assign cmd_reg   = reg_q;
   assign cmd_data  = dat_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = err_q;
   assign fail_addr = fail_q;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Directed testbench for i2c_cfg_sequencer: ROM model, scripted I2C master,
// and one task per scenario.
module tb_i2c_cfg_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  rom_addr;
   logic [31:0] rom_data = 32'h0;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [6:0]  cmd_dev;
   logic [7:0]  cmd_reg;
   logic [7:0]  cmd_data;
   logic        rsp_valid;
   logic        rsp_nack;
   logic        busy;
   logic        done;
   logic        error;
   logic [3:0]  fail_addr;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] rom [0:15];
   int          nack_left [0:15];
   int          stall_cycles = 0;
   int          rsp_lat = 5;
   int          hs_n = 0;
   logic [6:0]  hs_dev  [0:31];
   logic [7:0]  hs_reg  [0:31];
   logic [7:0]  hs_dat  [0:31];
   logic [3:0]  hs_addr [0:31];

   i2c_cfg_sequencer #(
      .LINES(16), .DW(32), .MAX_RETRY(3), .DELAY_SHIFT(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_nack(rsp_nack),
      .busy(busy), .done(done), .error(error), .fail_addr(fail_addr)
   );

   always #5 clk = ~clk;

   // Synchronous-read ROM: data appears one cycle after the address
   always @(posedge clk) rom_data <= rom[rom_addr];

   // Scripted I2C master: ready after stall_cycles, response rsp_lat cycles
   // after the handshake, NACKs taken from nack_left per ROM address.
   initial begin : master
      int wc;
      int rc;
      bit pend;
      logic [3:0] cur;
      cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0;
      wc = 0; rc = 0; pend = 1'b0; cur = '0;
      forever begin
         @(negedge clk);
         rsp_valid = 1'b0;
         rsp_nack  = 1'b0;
         if (!rst_n) begin
            cmd_ready = 1'b0; pend = 1'b0; wc = 0;
         end else if (cmd_ready) begin
            cmd_ready = 1'b0;
            if (hs_n < 32) begin
               hs_dev[hs_n]  = cmd_dev;
               hs_reg[hs_n]  = cmd_reg;
               hs_dat[hs_n]  = cmd_data;
               hs_addr[hs_n] = rom_addr;
            end
            hs_n = hs_n + 1;
            pend = 1'b1; rc = 0; cur = rom_addr;
         end else if (pend) begin
            rc = rc + 1;
            if (rc >= rsp_lat) begin
               rsp_valid = 1'b1;
               if (nack_left[cur] > 0) begin
                  rsp_nack = 1'b1;
                  nack_left[cur] = nack_left[cur] - 1;
               end
               pend = 1'b0;
            end
         end else if (cmd_valid) begin
            if (wc >= stall_cycles) begin
               cmd_ready = 1'b1; wc = 0;
            end else begin
               wc = wc + 1;
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
      $fatal(1, "timeout");
   end

   task automatic fill_rom();
      for (int i = 0; i < 16; i++) begin
         rom[i] = 32'hFF00_0000;
         nack_left[i] = 0;
      end
   endtask

   // Pulse start for one cycle; returns at the negedge after the accepting edge
   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         if (!busy && (done || error)) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_cmp++; if (rom_addr !== 4'd0) begin n_err++; $display("FAIL rst_rom_addr: got %0d want 0", rom_addr); end
      n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL rst_cmd_valid: got %b want 0", cmd_valid); end
      n_cmp++; if ({cmd_dev, cmd_reg, cmd_data} !== 23'd0) begin n_err++; $display("FAIL rst_cmd_fields: got %h want 0", {cmd_dev, cmd_reg, cmd_data}); end
      n_cmp++; if ({busy, done, error} !== 3'b000) begin n_err++; $display("FAIL rst_status: got %b want 000", {busy, done, error}); end
      n_cmp++; if (fail_addr !== 4'd0) begin n_err++; $display("FAIL rst_fail_addr: got %0d want 0", fail_addr); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      bit ok;
      fill_rom();
      rom[0] = 32'h0072_4110;
      rom[1] = 32'h0072_9803;
      rom[2] = 32'hFF00_0000;
      hs_n = 0; stall_cycles = 0; rsp_lat = 5;
      do_start();
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_after_start: got %b want 1", busy); end
      wait_idle(400, ok);
      n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL basic_timeout: got not-idle want idle"); end
      n_cmp++; if (hs_n !== 2) begin n_err++; $display("FAIL basic_hs_count: got %0d want 2", hs_n); end
      n_cmp++; if ({hs_dev[0], hs_reg[0], hs_dat[0]} !== {7'h39, 8'h41, 8'h10}) begin n_err++;
         $display("FAIL basic_hs0: got %h/%h/%h want 39/41/10", hs_dev[0], hs_reg[0], hs_dat[0]); end
      n_cmp++; if ({hs_dev[1], hs_reg[1], hs_dat[1]} !== {7'h39, 8'h98, 8'h03}) begin n_err++;
         $display("FAIL basic_hs1: got %h/%h/%h want 39/98/03", hs_dev[1], hs_reg[1], hs_dat[1]); end
      n_cmp++; if ({done, busy, error} !== 3'b100) begin n_err++; $display("FAIL basic_status: got %b want 100", {done, busy, error}); end
      n_cmp++; if (rom_addr !== 4'd2) begin n_err++; $display("FAIL basic_rom_addr: got %0d want 2", rom_addr); end
   endtask

   task automatic test_stall();
      bit ok;
      bit seen;
      bit stable;
      fill_rom();
      rom[0] = 32'h005A_1234;  // dev 0x2D, reg 0x12, data 0x34
      hs_n = 0; stall_cycles = 20; rsp_lat = 3;
      do_start();
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (cmd_valid) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL stall_valid_seen: got no cmd_valid want cmd_valid"); end
      stable = 1'b1;
      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         if (cmd_valid !== 1'b1 || {cmd_dev, cmd_reg, cmd_data} !== {7'h2D, 8'h12, 8'h34} || hs_n !== 0)
            stable = 1'b0;
      end
      n_cmp++; if (stable !== 1'b1) begin n_err++; $display("FAIL stall_stable: got changed request want held request"); end
      wait_idle(200, ok);
      n_cmp++; if (ok !== 1'b1 || done !== 1'b1) begin n_err++; $display("FAIL stall_done: got ok=%b done=%b want 1/1", ok, done); end
      n_cmp++; if (hs_n !== 1) begin n_err++; $display("FAIL stall_hs_count: got %0d want 1", hs_n); end
      stall_cycles = 0;
   endtask

   task automatic test_nack_retry();
      bit ok;
      bit same;
      fill_rom();
      rom[0] = 32'h0072_4110;
      rom[1] = 32'h0072_9803;
      rom[2] = 32'hFF00_0000;
      nack_left[1] = 4;
      hs_n = 0; rsp_lat = 2;
      do_start();
      wait_idle(600, ok);
      n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL nack_timeout: got not-idle want idle"); end
      n_cmp++; if (hs_n !== 5) begin n_err++; $display("FAIL nack_hs_count: got %0d want 5", hs_n); end
      same = 1'b1;
      for (int i = 1; i < 5; i++)
         if (hs_addr[i] !== 4'd1 || hs_reg[i] !== 8'h98) same = 1'b0;
      n_cmp++; if (same !== 1'b1) begin n_err++; $display("FAIL nack_same_entry: got differing entries want entry 1 x4"); end
      n_cmp++; if ({done, busy, error} !== 3'b001) begin n_err++; $display("FAIL nack_status: got %b want 001", {done, busy, error}); end
      n_cmp++; if (fail_addr !== 4'd1) begin n_err++; $display("FAIL nack_fail_addr: got %0d want 1", fail_addr); end
      // Rerun clean: error clears on the accepted start, sequence restarts at 0
      fill_rom();
      rom[0] = 32'h0072_4110;
      rom[1] = 32'h0072_9803;
      hs_n = 0;
      do_start();
      n_cmp++; if ({error, done} !== 2'b00) begin n_err++; $display("FAIL nack_restart_clear: got %b want 00", {error, done}); end
      wait_idle(400, ok);
      n_cmp++; if ({ok, done, error} !== 3'b110) begin n_err++; $display("FAIL nack_rerun: got %b want 110", {ok, done, error}); end
      n_cmp++; if (hs_n !== 2 || hs_addr[0] !== 4'd0) begin n_err++; $display("FAIL nack_rerun_hs: got %0d@%0d want 2@0", hs_n, hs_addr[0]); end
   endtask

   // Start edge = edge 1; FETCH,LATCH,DECODE leave DECODE on edge 4.
   // Delay 2<<2 = 8 cycles -> NEXT on edge 12 -> FETCH(addr 1) on edge 13.
   // A NOP goes DECODE->NEXT on edge 4 -> FETCH(addr 1) on edge 5.
   task automatic test_delay();
      bit ok;
      int k;
      fill_rom();
      rom[0] = 32'h0100_0002;
      hs_n = 0;
      do_start();
      k = 1;
      while (k < 40 && rom_addr !== 4'd1) begin
         @(negedge clk);
         k++;
      end
      n_cmp++; if (k !== 13) begin n_err++; $display("FAIL delay_fetch_edge: got %0d want 13", k); end
      wait_idle(100, ok);
      n_cmp++; if ({ok, done} !== 2'b11) begin n_err++; $display("FAIL delay_done: got %b want 11", {ok, done}); end
      rom[0] = 32'h5500_0000;
      do_start();
      k = 1;
      while (k < 40 && rom_addr !== 4'd1) begin
         @(negedge clk);
         k++;
      end
      n_cmp++; if (k !== 5) begin n_err++; $display("FAIL nop_fetch_edge: got %0d want 5", k); end
      wait_idle(100, ok);
      n_cmp++; if (hs_n !== 0 || done !== 1'b1) begin n_err++; $display("FAIL nop_done: got hs=%0d done=%b want 0/1", hs_n, done); end
   endtask

   task automatic test_no_end();
      bit fin;
      bit saw15;
      bit wrapped;
      bit order_ok;
      fill_rom();
      for (int i = 0; i < 16; i++) rom[i] = {8'h00, 8'h72, 8'h20, 8'(i)};
      hs_n = 0; rsp_lat = 1;
      do_start();
      fin = 1'b0; saw15 = 1'b0; wrapped = 1'b0;
      for (int i = 0; i < 800 && !fin; i++) begin
         if (rom_addr === 4'd15) saw15 = 1'b1;
         else if (saw15 && rom_addr === 4'd0) wrapped = 1'b1;
         if (!busy && (done || error)) fin = 1'b1;
         else @(negedge clk);
      end
      n_cmp++; if ({fin, done, error} !== 3'b110) begin n_err++; $display("FAIL noend_status: got %b want 110", {fin, done, error}); end
      n_cmp++; if (hs_n !== 16) begin n_err++; $display("FAIL noend_hs_count: got %0d want 16", hs_n); end
      order_ok = 1'b1;
      for (int i = 0; i < 16; i++)
         if (hs_dat[i] !== 8'(i) || hs_addr[i] !== 4'(i) || hs_reg[i] !== 8'h20) order_ok = 1'b0;
      n_cmp++; if (order_ok !== 1'b1) begin n_err++; $display("FAIL noend_order: got out-of-order entries want 0..15"); end
      n_cmp++; if (wrapped !== 1'b0 || rom_addr !== 4'd15) begin n_err++; $display("FAIL noend_wrap: got wrap=%b addr=%0d want 0/15", wrapped, rom_addr); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit got;
      fill_rom();
      rom[0] = 32'h5500_0000;
      rom[1] = 32'h0072_4110;
      hs_n = 0; rsp_lat = 1000;
      do_start();
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (hs_n == 1) got = 1'b1;
      end
      n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL rmid_handshake: got none want 1"); end
      repeat (3) @(negedge clk);
      n_cmp++; if ({busy, cmd_dev} !== {1'b1, 7'h39}) begin n_err++; $display("FAIL rmid_pre: got %b/%h want 1/39", busy, cmd_dev); end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({rom_addr, cmd_valid, cmd_dev, cmd_reg, cmd_data, busy, done, error, fail_addr} !== 39'd0) begin n_err++;
         $display("FAIL rmid_async_clear: got addr=%0d v=%b dev=%h busy=%b fa=%0d want all 0", rom_addr, cmd_valid, cmd_dev, busy, fail_addr); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rsp_lat = 2; hs_n = 0;
      @(negedge clk);
      do_start();
      n_cmp++; if (rom_addr !== 4'd0) begin n_err++; $display("FAIL rmid_restart_addr: got %0d want 0", rom_addr); end
      wait_idle(200, ok);
      n_cmp++; if ({ok, done, error} !== 3'b110 || hs_n !== 1 || hs_addr[0] !== 4'd1) begin n_err++;
         $display("FAIL rmid_rerun: got %b hs=%0d@%0d want 110 hs=1@1", {ok, done, error}, hs_n, hs_addr[0]); end
   endtask

   initial begin : main
      fill_rom();
      test_reset();
      test_basic();
      test_stall();
      test_nack_retry();
      test_delay();
      test_no_end();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/i2c_cfg_sequencer.md
Name: i2c_cfg_sequencer

Overview:
- Reader side of the I2C configuration ROM: walks a synchronous-read ROM of command words and turns each into a register-write transaction for the I2C byte master that configures the HDMI transmitter.
- Supports write, delay and end opcodes, NACK retry, and done/error status for the top-level bring-up FSM.

Parameters:
- LINES, 16, ROM depth in words; address width is clog2(LINES).
- DW, 32, ROM word width; fixed at 32 by the command format.
- MAX_RETRY, 3, maximum re-issues of a NACKed write before error.
- DELAY_SHIFT, 10, delay opcode waits data16 << DELAY_SHIFT clock cycles.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins the sequence from address 0 when idle
- rom_addr  out  clog2(LINES)  ROM read address
- rom_data  in  DW  ROM data, valid one cycle after rom_addr is presented
- cmd_valid  out  1  write request to the I2C master
- cmd_ready  in  1  master accepts the request
- cmd_dev  out  7  7-bit device address
- cmd_reg  out  8  register address
- cmd_data  out  8  register data
- rsp_valid  in  1  one-cycle pulse; transaction finished
- rsp_nack  in  1  qualified by rsp_valid; 1 = NACK seen
- busy  out  1  sequence in progress
- done  out  1  sticky; sequence completed
- error  out  1  sticky; retries exhausted
- fail_addr  out  clog2(LINES)  ROM address of the failing entry

Behaviour:
- Reset (asynchronous, active-low): state IDLE; rom_addr, cmd_*, busy, done, error, fail_addr = 0; retry count and delay counter = 0.
- Word format:
  - [31:24] opcode: 0x00 = WRITE, 0x01 = DELAY, 0xFF = END.
  - [23:17] device address.
  - [15:8] register.
  - [7:0] data.
  - DELAY uses [15:0] as its count.
  - Any other opcode is treated as NOP: advance to the next entry.
- States: IDLE, FETCH, LATCH, DECODE, ISSUE, WAIT_RSP, DELAY, NEXT, FINISH, FAIL.
- IDLE:
  - start → clear done, error and retry count; rom_addr = 0; go to FETCH; busy = 1 from the next cycle.
  - start while not in IDLE is ignored.
- FETCH → LATCH → DECODE: one wait cycle covers the ROM read latency. rom_data is registered in LATCH and decoded in DECODE. Fetch-to-decode is 3 cycles.
- DECODE transitions:
  - WRITE → ISSUE.
  - DELAY → DELAY with counter = data16 << DELAY_SHIFT; a count of 0 goes straight to NEXT.
  - END → FINISH.
  - Other → NEXT.
- ISSUE:
  - cmd_valid = 1; cmd_dev, cmd_reg and cmd_data stay stable while cmd_valid is high.
  - On cmd_valid && cmd_ready, deassert cmd_valid the next cycle and go to WAIT_RSP.
  - cmd_valid never drops without a handshake.
- WAIT_RSP:
  - rsp_valid && !rsp_nack → reset retry count; go to NEXT.
  - rsp_valid && rsp_nack:
    - retry count < MAX_RETRY → increment it; go to ISSUE (same entry, no refetch).
    - Otherwise → FAIL.
  - rsp_valid arriving in the same cycle as the cmd handshake is not allowed (master contract). It is ignored if it occurs.
- DELAY: decrement the counter each cycle; at 1 go to NEXT. Counter width is 16 + DELAY_SHIFT bits, so there is no overflow.
- NEXT:
  - rom_addr == LINES-1 → FINISH. Implicit end; no wrap-around.
  - Otherwise rom_addr + 1 → FETCH.
- FINISH: done = 1, busy = 0; go to IDLE.
- FAIL: error = 1, fail_addr = rom_addr, busy = 0; go to IDLE.
- done and error hold until the next accepted start.
- Reset mid-operation aborts immediately. Any pending cmd_valid drops asynchronously. The master is responsible for releasing the bus on its own reset.

Test Plan:
- ROM {0x00_72_41_10, 0x00_72_98_03, 0xFF000000}, start, master acks after 5 cycles → two handshakes with (dev 0x39, reg 0x41, data 0x10) then (0x39, 0x98, 0x03); done=1, busy=0, error=0; rom_addr stops at 2.
- cmd_ready held low 20 cycles in ISSUE → cmd_valid stays 1 and cmd_* stay constant; exactly one handshake is counted.
- Entry 1 NACKs 4 consecutive times with MAX_RETRY=3 → 4 issues of the same entry, then error=1, fail_addr=1, done=0; a new start clears error and reruns from address 0.
- Entry 0 = 0x01_00_00_02 with DELAY_SHIFT=2 → 8 cycles in DELAY; the next fetch of address 1 starts exactly 8 cycles after DECODE.
- ROM with no END (16 WRITEs) → 16 transactions, then done=1; no access to address 0 after address 15.
- rst_n asserted during WAIT_RSP → all outputs return to 0 asynchronously; a start after reset release begins at address 0.
